// File: rtl/ntt_pkg.sv
// Shared definitions for the Kyber NTT core: mode codes, ring constants and
// the scheduler state encoding.
package ntt_pkg;

    localparam logic [1:0] MODE_NTT  = 2'b00;
    localparam logic [1:0] MODE_INTT = 2'b01;
    localparam logic [1:0] MODE_IN   = 2'b10;
    localparam logic [1:0] MODE_OUT  = 2'b11;

    localparam int N_COEF   = 256;
    localparam int N_LAYERS = 7;
    localparam int KYBER_Q  = 3329;
    localparam int N_INV    = 1441;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FIN   = 3'd3,
        ST_SCALE = 3'd4
    } sched_state_e;

endpackage

// File: rtl/ntt_pipe_delay.sv
// Fixed-depth shift register with asynchronous clear; aligns write-back
// strobes and addresses with the butterfly datapath latency.
module ntt_pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_q [DEPTH];
    logic [WIDTH-1:0] pipe_d [DEPTH];

    always_comb begin
        pipe_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_bfly_sched.sv
// Butterfly address/twiddle scheduler for the 256-point Kyber NTT/INTT.
// Optional INTT n^-1 scaling pass enabled by NTT_BFLY_SCHED_INTT_SCALE_EN.
module ntt_bfly_sched
    import ntt_pkg::*;
#(
    parameter int N        = 256,
    parameter int LAYERS   = 7,
    parameter int ADDR_W   = 8,
    parameter int TW_W     = 7,
    parameter int PIPE_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              stall,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic [TW_W-1:0]   tw_idx,
    output logic              inv,
    output logic              newloop,
    output logic              wen,
    output logic [ADDR_W-1:0] wr_addr_a,
    output logic [ADDR_W-1:0] wr_addr_b,
    output logic              busy,
    output logic              done
`ifdef NTT_BFLY_SCHED_INTT_SCALE_EN
    ,
    output logic              scale
`endif
);

    localparam int              K_W    = ADDR_W - 1;
    localparam logic [K_W-1:0]  K_LAST = K_W'(N / 2 - 1);
    localparam logic [2:0]      L_LAST = 3'(LAYERS - 1);
    localparam logic [2:0]      L_TOP  = 3'(ADDR_W - 1);
    localparam logic [3:0]      D_LAST = 4'(PIPE_LAT - 1);
    localparam int              WB_W   = 2 * ADDR_W + 1;

    sched_state_e      state_q, state_d;
    logic [2:0]        layer_q, layer_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [3:0]        dcnt_q, dcnt_d;
    logic              inv_q, inv_d;
    logic              issuing;
`ifdef NTT_BFLY_SCHED_INTT_SCALE_EN
    logic              scale_pass_q, scale_pass_d;

    assign issuing = (state_q == ST_ISSUE) || (state_q == ST_SCALE);
`else
    assign issuing = (state_q == ST_ISSUE);
`endif

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        k_d     = k_q;
        dcnt_d  = dcnt_q;
        inv_d   = inv_q;
`ifdef NTT_BFLY_SCHED_INTT_SCALE_EN
        scale_pass_d = scale_pass_q;
`endif
        if (issuing && !stall) begin
            k_d = k_q + 1'b1;
            if (k_q == K_LAST) begin
                state_d = ST_DRAIN;
                dcnt_d  = '0;
            end
        end
        case (state_q)
            ST_IDLE: begin
                if (start && (mode == MODE_NTT || mode == MODE_INTT)) begin
                    inv_d   = (mode == MODE_INTT);
                    layer_d = '0;
                    k_d     = '0;
                    state_d = ST_ISSUE;
`ifdef NTT_BFLY_SCHED_INTT_SCALE_EN
                    scale_pass_d = 1'b0;
`endif
                end
            end
            // Drain ignores stall so every write of a layer lands before the next read.
            ST_DRAIN: begin
                dcnt_d = dcnt_q + 1'b1;
                if (dcnt_q == D_LAST) begin
                    k_d = '0;
                    if (layer_q != L_LAST) begin
                        layer_d = layer_q + 1'b1;
                        state_d = ST_ISSUE;
                    end
`ifdef NTT_BFLY_SCHED_INTT_SCALE_EN
                    else if (inv_q && !scale_pass_q) begin
                        scale_pass_d = 1'b1;
                        state_d      = ST_SCALE;
                    end
`endif
                    else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            layer_q <= '0;
            k_q     <= '0;
            dcnt_q  <= '0;
            inv_q   <= 1'b0;
`ifdef NTT_BFLY_SCHED_INTT_SCALE_EN
            scale_pass_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            k_q     <= k_d;
            dcnt_q  <= dcnt_d;
            inv_q   <= inv_d;
`ifdef NTT_BFLY_SCHED_INTT_SCALE_EN
            scale_pass_q <= scale_pass_d;
`endif
        end
    end

    // sh = log2(len): 7-l for Cooley-Tukey, l+1 for Gentleman-Sande.
    logic [2:0]        sh;
    logic [ADDR_W-1:0] k_ext, mask, grp, a_bfly, b_bfly;
    logic [TW_W-1:0]   tw_bfly;

    always_comb begin
        sh      = inv_q ? (layer_q + 3'd1) : (L_TOP - layer_q);
        k_ext   = {1'b0, k_q};
        mask    = (ADDR_W'(1) << sh) - ADDR_W'(1);
        grp     = k_ext >> sh;
        a_bfly  = (grp << ({1'b0, sh} + 4'd1)) | (k_ext & mask);
        b_bfly  = a_bfly | (ADDR_W'(1) << sh);
        tw_bfly = inv_q ? (({TW_W{1'b1}} >> layer_q) - TW_W'(grp))
                        : ((TW_W'(1) << layer_q) + TW_W'(grp));
    end

    always_comb begin
        rd_en     = issuing && !stall;
        rd_addr_a = '0;
        rd_addr_b = '0;
        tw_idx    = '0;
        newloop   = 1'b0;
        if (rd_en) begin
            rd_addr_a = a_bfly;
            rd_addr_b = b_bfly;
            tw_idx    = tw_bfly;
            newloop   = (k_q == '0);
`ifdef NTT_BFLY_SCHED_INTT_SCALE_EN
            if (state_q == ST_SCALE) begin
                rd_addr_a = {k_q, 1'b0};
                rd_addr_b = {k_q, 1'b1};
                tw_idx    = '0;
            end
`endif
        end
    end

`ifdef NTT_BFLY_SCHED_INTT_SCALE_EN
    assign scale = rd_en && (state_q == ST_SCALE);
`endif

    assign inv  = inv_q;
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_FIN);

    // Read addresses are zero when idle, so the delayed copies are zero whenever wen is low.
    logic [WB_W-1:0] wb_in, wb_out;

    assign wb_in = {rd_en, rd_addr_a, rd_addr_b};

    ntt_pipe_delay #(
        .WIDTH(WB_W),
        .DEPTH(PIPE_LAT)
    ) u_wb_delay (
        .clk (clk),
        .rst (rst),
        .din (wb_in),
        .dout(wb_out)
    );

    assign wen       = wb_out[WB_W-1];
    assign wr_addr_a = wb_out[2*ADDR_W-1:ADDR_W];
    assign wr_addr_b = wb_out[ADDR_W-1:0];

endmodule
